// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request; the slave (the subtractor) returns status and result.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock through a single
// full-subtractor cell and a registered borrow, framed by start/busy/done.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Single full-subtractor cell on the current LSBs
  logic d_c;
  logic borrow_c;
  assign d_c      = sa_q[0] ^ sb_q[0] ^ br_q;
  assign borrow_c = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = bus.bin;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = borrow_c;
        sr_d  = {d_c, sr_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        // Result publishes only on the final step, so diff never shows partial sums
        if (cnt_d == CW'(WIDTH)) begin
          diff_d  = sr_d;
          bout_d  = br_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, random operands,
// async reset mid-operation and a back-to-back exhaustive sweep against an integer model.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int          LIMIT = 20;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction interpreted as WIDTH+1-bit two's complement
  function automatic int ref_diff(input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    return r & ((1 << WIDTH) - 1);
  endfunction

  function automatic int ref_bout(input int a, input int b, input int bin);
    return (a - b - bin < 0) ? 1 : 0;
  endfunction

  // Advance on falling edges until done is seen or the budget runs out
  task automatic wait_done(input int n_in, output int n_out);
    n_out = n_in;
    while (!bus.done && n_out < LIMIT) begin
      @(negedge clk);
      n_out++;
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int bin);
    int n;
    bus.a     = WIDTH'(a);
    bus.b     = WIDTH'(b);
    bus.bin   = 1'(bin);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".busy_accept"}, 32'(bus.busy), 32'd1);
    wait_done(1, n);
    check({tag, ".latency"}, 32'(n), 32'(WIDTH + 1));
    check({tag, ".diff"}, 32'(bus.diff), 32'(ref_diff(a, b, bin)));
    check({tag, ".bout"}, 32'(bus.bout), 32'(ref_bout(a, b, bin)));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int ea, eb, ebin;
    int hold;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.diff", 32'(bus.diff), 32'd0);
    check("rst.bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations
    run_op("op_7m2", 4'b0111, 4'b0010, 0);
    run_op("op_2m7", 4'b0010, 4'b0111, 0);
    run_op("op_0m0b", 4'b0000, 4'b0000, 1);
    run_op("op_fmf", 4'b1111, 4'b1111, 0);
    run_op("op_am5", 4'b1010, 4'b0101, 0);

    // Result holds between operations
    hold = ref_diff(4'b1010, 4'b0101, 0);
    repeat (3) @(negedge clk);
    check("hold.diff", 32'(bus.diff), 32'(hold));
    check("hold.busy", 32'(bus.busy), 32'd0);

    // Random operands
    for (int i = 0; i < 8; i++) begin
      run_op("rand", int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
    end

    // Input changes and start requests during an operation are ignored
    bus.a     = 4'b0111;
    bus.b     = 4'b0010;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a   = 4'b0001;
    bus.b   = 4'b0001;
    bus.bin = 1'b0;
    n = 1;
    while (!bus.done && n < LIMIT) begin
      @(negedge clk);
      n++;
      bus.a   = WIDTH'($urandom);
      bus.b   = WIDTH'($urandom);
      bus.bin = 1'($urandom);
    end
    check("ign.latency", 32'(n), 32'(WIDTH + 1));
    check("ign.diff", 32'(bus.diff), 32'b0101);
    check("ign.bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    check("ign.done_drop", 32'(bus.done), 32'd0);
    check("ign.busy_idle", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    check("ign.not_accepted", 32'(bus.busy), 32'd0);

    // Async reset mid-SHIFT discards the operation
    bus.a     = 4'b1111;
    bus.b     = 4'b0001;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst.busy", 32'(bus.busy), 32'd0);
    check("mrst.done", 32'(bus.done), 32'd0);
    check("mrst.diff", 32'(bus.diff), 32'd0);
    check("mrst.bout", 32'(bus.bout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mrst.no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    run_op("post_rst", 4'b0110, 4'b0011, 0);

    // Exhaustive sweep with start held high back to back
    bus.start = 1'b1;
    for (int i = 0; i < (1 << (2 * WIDTH + 1)); i++) begin
      ea   = i & 15;
      eb   = (i >> 4) & 15;
      ebin = (i >> 8) & 1;
      bus.a   = WIDTH'(ea);
      bus.b   = WIDTH'(eb);
      bus.bin = 1'(ebin);
      @(negedge clk);
      wait_done(1, n);
      check((i == 0) ? "sweep.latency" : "sweep.spacing", 32'(n), (i == 0) ? 32'(WIDTH + 1) : 32'(WIDTH + 2));
      check("sweep.diff", 32'(bus.diff), 32'(ref_diff(ea, eb, ebin)));
      check("sweep.bout", 32'(bus.bout), 32'(ref_bout(ea, eb, ebin)));
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("sweep.idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
